// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with step enable, seed load, period measurement and lock-up detect.
// Optional macro LFSR_LOCKUP_RECOVER_EN: an all-zero state is forced back to INIT on the next edge.
module lfsr_gen #(
    parameter int              WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
    parameter int              MODE  = 0,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] step_cnt,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] nxt;
    logic             hit;

    always_comb begin
        nxt = '0;
        if (MODE != 0)
            nxt = {q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q[WIDTH-1]}} & TAPS);
        else
            nxt = {q[WIDTH-2:0], ^(q & TAPS)};
    end

    // A step closes a cycle when it lands back on the value measurement began from.
    assign hit        = (nxt == start);
    assign serial_out = q[WIDTH-1];
    assign lockup     = (q == '0);

    always_ff @(posedge Clock) begin
        if (reset) begin
            q        <= INIT;
            start    <= INIT;
            step_cnt <= '0;
            period   <= '0;
            wrap     <= 1'b0;
        end else if (load) begin
            q        <= seed;
            start    <= seed;
            step_cnt <= '0;
            wrap     <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        end else if (lockup) begin
            q        <= INIT;
            start    <= INIT;
            step_cnt <= '0;
            wrap     <= 1'b0;
`else
        end else if (lockup) begin
            // Zero is absorbing: no counting or wrap while stuck.
            wrap     <= 1'b0;
`endif
        end else if (en) begin
            q <= nxt;
            if (hit) begin
                wrap     <= 1'b1;
                period   <= step_cnt + ONE;
                step_cnt <= '0;
            end else begin
                wrap     <= 1'b0;
                step_cnt <= step_cnt + ONE;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: default Fibonacci instance plus a Galois instance.
// Honours LFSR_LOCKUP_RECOVER_EN when the bench is built with it.
module tb_lfsr_gen;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic [4:0] seed  = '0;

    logic [4:0] fq, fper, fcnt, gq, gper, gcnt;
    logic       fser, fwrap, flock, gser, gwrap, glock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wrap;
        logic [4:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] eq[$];

    always #5 Clock = ~Clock;

    lfsr_gen u_fib (
        .Clock(Clock), .reset(reset), .en(en), .load(load), .seed(seed),
        .q(fq), .serial_out(fser), .wrap(fwrap), .period(fper),
        .step_cnt(fcnt), .lockup(flock)
    );

    lfsr_gen #(.WIDTH(5), .TAPS(5'b00101), .MODE(1)) u_gal (
        .Clock(Clock), .reset(reset), .en(en), .load(load), .seed(seed),
        .q(gq), .serial_out(gser), .wrap(gwrap), .period(gper),
        .step_cnt(gcnt), .lockup(glock)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; load = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fq !== 5'h1F) begin errors++; $display("FAIL reset_q: got %h want 1f", fq); end
        checks++; if (fcnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", fcnt); end
        checks++; if (fper !== 5'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", fper); end
        checks++; if (fwrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", fwrap); end
        checks++; if (flock !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b want 0", flock); end
        checks++; if (gq !== 5'h1F) begin errors++; $display("FAIL reset_gq: got %h want 1f", gq); end
    endtask

    task automatic test_fib_seq();
        logic [4:0] tbl[4] = '{5'h1E, 5'h1C, 5'h18, 5'h11};
        logic [4:0] e;
        do_reset();
        checks++; if (fser !== 1'b1) begin errors++; $display("FAIL fib_ser0: got %b want 1", fser); end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eq.push_back(tbl[k]);
            tick();
            e = eq.pop_front();
            checks++; if (fq !== e) begin errors++; $display("FAIL fib_q%0d: got %h want %h", k, fq, e); end
            checks++; if (fser !== 1'b1) begin errors++; $display("FAIL fib_ser%0d: got %b want 1", k, fser); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        bit seen[32];
        int n = 0;
        exp_t x;
        do_reset();
        seen[fq] = 1'b1; n = 1;
        en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            sb.push_back('{wrap: (i == 31), cnt: (i == 31) ? 5'd0 : 5'(i)});
            tick();
            x = sb.pop_front();
            if (!seen[fq]) begin seen[fq] = 1'b1; n++; end
            checks++; if (fwrap !== x.wrap) begin errors++; $display("FAIL wrap_pulse step %0d: got %b want %b", i, fwrap, x.wrap); end
            checks++; if (fcnt !== x.cnt) begin errors++; $display("FAIL wrap_cnt step %0d: got %0d want %0d", i, fcnt, x.cnt); end
        end
        checks++; if (fq !== 5'h1F) begin errors++; $display("FAIL wrap_q: got %h want 1f", fq); end
        checks++; if (fper !== 5'd31) begin errors++; $display("FAIL wrap_period: got %0d want 31", fper); end
        checks++; if (n !== 31) begin errors++; $display("FAIL wrap_distinct: got %0d want 31", n); end
        en = 1'b0;
        tick();
        checks++; if (fwrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle: got %b want 0", fwrap); end
    endtask

    task automatic test_en_toggle();
        logic       pat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0] eqv[4]  = '{5'h1E, 5'h1E, 5'h1E, 5'h1C};
        logic [4:0] ecnt[4] = '{5'd1, 5'd1, 5'd1, 5'd2};
        exp_t x;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            en = pat[k];
            sb.push_back('{wrap: 1'b0, cnt: ecnt[k]});
            eq.push_back(eqv[k]);
            tick();
            x = sb.pop_front();
            checks++; if (fq !== eq[0]) begin errors++; $display("FAIL toggle_q%0d: got %h want %h", k, fq, eq[0]); end
            void'(eq.pop_front());
            checks++; if (fcnt !== x.cnt) begin errors++; $display("FAIL toggle_cnt%0d: got %0d want %0d", k, fcnt, x.cnt); end
            checks++; if (fwrap !== x.wrap) begin errors++; $display("FAIL toggle_wrap%0d: got %b want 0", k, fwrap); end
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        exp_t x;
        do_reset();
        en = 1'b1;
        repeat (3) tick();
        load = 1'b1; seed = 5'h05;
        tick();
        load = 1'b0;
        checks++; if (fq !== 5'h05) begin errors++; $display("FAIL load_q: got %h want 05", fq); end
        checks++; if (fcnt !== 5'd0) begin errors++; $display("FAIL load_cnt: got %0d want 0", fcnt); end
        checks++; if (fwrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %b want 0", fwrap); end
        checks++; if (fper !== 5'd0) begin errors++; $display("FAIL load_period_kept: got %0d want 0", fper); end
        for (int i = 1; i <= 31; i++) begin
            sb.push_back('{wrap: (i == 31), cnt: (i == 31) ? 5'd0 : 5'(i)});
            tick();
            x = sb.pop_front();
            checks++; if (fwrap !== x.wrap) begin errors++; $display("FAIL load_wrap step %0d: got %b want %b", i, fwrap, x.wrap); end
        end
        checks++; if (fq !== 5'h05) begin errors++; $display("FAIL load_wrap_q: got %h want 05", fq); end
        checks++; if (fper !== 5'd31) begin errors++; $display("FAIL load_period: got %0d want 31", fper); end
        en = 1'b0;
    endtask

    task automatic test_galois();
        logic [4:0] gt[2] = '{5'h1B, 5'h13};
        logic [4:0] e;
        exp_t x;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            if (i <= 2) eq.push_back(gt[i-1]);
            sb.push_back('{wrap: (i == 31), cnt: (i == 31) ? 5'd0 : 5'(i)});
            tick();
            x = sb.pop_front();
            if (i <= 2) begin
                e = eq.pop_front();
                checks++; if (gq !== e) begin errors++; $display("FAIL gal_q%0d: got %h want %h", i, gq, e); end
            end
            checks++; if (gwrap !== x.wrap) begin errors++; $display("FAIL gal_wrap step %0d: got %b want %b", i, gwrap, x.wrap); end
        end
        checks++; if (gper !== 5'd31) begin errors++; $display("FAIL gal_period: got %0d want 31", gper); end
        checks++; if (gq !== 5'h1F) begin errors++; $display("FAIL gal_wrap_q: got %h want 1f", gq); end
        do_reset();
        en = 1'b1;
        repeat (10) tick();
        checks++; if (gcnt !== 5'd10) begin errors++; $display("FAIL gal_cnt10: got %0d want 10", gcnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0;
        checks++; if (gq !== 5'h1F) begin errors++; $display("FAIL gal_midreset_q: got %h want 1f", gq); end
        checks++; if (gper !== 5'd0) begin errors++; $display("FAIL gal_midreset_period: got %0d want 0", gper); end
        checks++; if (gcnt !== 5'd0) begin errors++; $display("FAIL gal_midreset_cnt: got %0d want 0", gcnt); end
    endtask

    task automatic test_lockup();
        do_reset();
        load = 1'b1; seed = 5'h00;
        tick();
        load = 1'b0;
        checks++; if (fq !== 5'h00) begin errors++; $display("FAIL lock_q0: got %h want 00", fq); end
        checks++; if (flock !== 1'b1) begin errors++; $display("FAIL lock_flag: got %b want 1", flock); end
`ifdef LFSR_LOCKUP_RECOVER_EN
        tick();
        checks++; if (fq !== 5'h1F) begin errors++; $display("FAIL lock_recover_q: got %h want 1f", fq); end
        checks++; if (flock !== 1'b0) begin errors++; $display("FAIL lock_recover_flag: got %b want 0", flock); end
        checks++; if (fcnt !== 5'd0) begin errors++; $display("FAIL lock_recover_cnt: got %0d want 0", fcnt); end
`else
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (fq !== 5'h00) begin errors++; $display("FAIL lock_stuck_q%0d: got %h want 00", k, fq); end
            checks++; if (flock !== 1'b1) begin errors++; $display("FAIL lock_stuck_flag%0d: got %b want 1", k, flock); end
        end
        en = 1'b0;
`endif
        do_reset();
        checks++; if (flock !== 1'b0) begin errors++; $display("FAIL lock_cleared: got %b want 0", flock); end
    endtask

    initial begin
        test_reset();
        test_fib_seq();
        test_wrap();
        test_en_toggle();
        test_load();
        test_galois();
        test_lockup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
